// File: rtl/escaner_teclado_pkg.sv
// Shared definitions for the keypad scanner: key codes, FSM states and the
// (row, column) to key-code map. The seven-segment converter uses the same codes.
package escaner_teclado_pkg;

   localparam logic [3:0] TECLA_0     = 4'h0;
   localparam logic [3:0] TECLA_1     = 4'h1;
   localparam logic [3:0] TECLA_2     = 4'h2;
   localparam logic [3:0] TECLA_3     = 4'h3;
   localparam logic [3:0] TECLA_4     = 4'h4;
   localparam logic [3:0] TECLA_5     = 4'h5;
   localparam logic [3:0] TECLA_6     = 4'h6;
   localparam logic [3:0] TECLA_7     = 4'h7;
   localparam logic [3:0] TECLA_8     = 4'h8;
   localparam logic [3:0] TECLA_9     = 4'h9;
   localparam logic [3:0] TECLA_MAS   = 4'hA;
   localparam logic [3:0] TECLA_MENOS = 4'hB;
   localparam logic [3:0] TECLA_POR   = 4'hC;
   localparam logic [3:0] TECLA_DIV   = 4'hD;
   localparam logic [3:0] TECLA_IGUAL = 4'hE;
   localparam logic [3:0] TECLA_NUL   = 4'hF;

   typedef enum logic [1:0] {
      EST_SCAN     = 2'd0,
      EST_DEBOUNCE = 2'd1,
      EST_PRESSED  = 2'd2,
      EST_RELEASE  = 2'd3
   } estado_t;

   function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
      logic [3:0] codigo;
      case ({fila, col})
         4'h0: codigo = TECLA_1;
         4'h1: codigo = TECLA_2;
         4'h2: codigo = TECLA_3;
         4'h3: codigo = TECLA_MAS;
         4'h4: codigo = TECLA_4;
         4'h5: codigo = TECLA_5;
         4'h6: codigo = TECLA_6;
         4'h7: codigo = TECLA_MENOS;
         4'h8: codigo = TECLA_7;
         4'h9: codigo = TECLA_8;
         4'hA: codigo = TECLA_9;
         4'hB: codigo = TECLA_POR;
         4'hC: codigo = TECLA_NUL;   // '*' doubles as clear
         4'hD: codigo = TECLA_0;
         4'hE: codigo = TECLA_IGUAL; // '#'
         default: codigo = TECLA_DIV;
      endcase
      return codigo;
   endfunction

   // Rows are active-low; the lowest-index low row wins.
   function automatic logic [1:0] fila_baja(input logic [3:0] filas);
      logic [1:0] idx;
      if (!filas[0])      idx = 2'd0;
      else if (!filas[1]) idx = 2'd1;
      else if (!filas[2]) idx = 2'd2;
      else                idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/escaner_teclado_sincronizador.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to 4'hF so that no key appears pressed while the chain refills.
module sincronizador_filas (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] filas_i,
   output logic [3:0] filas_s_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   // NOTE: non-blocking assignments let both flops sample the old values,
   // giving a true two-stage chain instead of a single wire-through.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= filas_i;
         sync_q <= meta_q;
      end
   end

   assign filas_s_o = sync_q;

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 matrix keypad scanner: walks one-cold columns, debounces the captured
// row on scan ticks and emits a registered key code with a one-cycle strobe.
module escaner_teclado
   import escaner_teclado_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] filas,
   output logic [3:0] columnas,
   output logic [3:0] tecla,
   output logic       tecla_valida,
   output logic       tecla_activa
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_ULT   = DW'(DEBOUNCE_CNT - 1);

   logic [3:0]    filas_s;
   logic [PW-1:0] presc_q;
   logic          tick;
   logic          cap_baja;

   estado_t       estado_q, estado_d;
   logic [1:0]    col_q, col_d;
   logic [1:0]    fila_q, fila_d;
   logic [DW-1:0] deb_q, deb_d;
   logic [3:0]    tecla_q, tecla_d;
   logic          valida_q, valida_d;
   logic          activa_q, activa_d;
   logic [3:0]    columnas_q, columnas_d;

   sincronizador_filas u_sincronizador (
      .clk       (clk),
      .rst       (rst),
      .filas_i   (filas),
      .filas_s_o (filas_s)
   );

   assign tick     = (presc_q == PRESC_MAX);
   assign cap_baja = ~filas_s[fila_q];

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      estado_d = estado_q;
      col_d    = col_q;
      fila_d   = fila_q;
      deb_d    = deb_q;
      tecla_d  = tecla_q;
      valida_d = 1'b0;
      if (tick) begin
         unique case (estado_q)
            EST_SCAN: begin
               if (filas_s == 4'hF) begin
                  col_d = col_q + 2'd1;
               end else begin
                  fila_d   = fila_baja(filas_s);
                  deb_d    = '0;
                  estado_d = EST_DEBOUNCE;
               end
            end
            EST_DEBOUNCE: begin
               if (!cap_baja) begin
                  estado_d = EST_SCAN;
                  col_d    = col_q + 2'd1;
               end else if (deb_q >= DEB_ULT) begin
                  estado_d = EST_PRESSED;
                  tecla_d  = codigo_tecla(fila_q, col_q);
                  valida_d = 1'b1;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end
            EST_PRESSED: begin
               // The first high tick already counts towards the release.
               if (!cap_baja) begin
                  if (DEBOUNCE_CNT <= 1) begin
                     estado_d = EST_SCAN;
                     col_d    = col_q + 2'd1;
                  end else begin
                     estado_d = EST_RELEASE;
                     deb_d    = DW'(1);
                  end
               end
            end
            EST_RELEASE: begin
               if (cap_baja) begin
                  deb_d = '0;
               end else if (deb_q >= DEB_ULT) begin
                  estado_d = EST_SCAN;
                  col_d    = col_q + 2'd1;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end
            default: estado_d = EST_SCAN;
         endcase
      end
      activa_d   = (estado_d == EST_PRESSED) || (estado_d == EST_RELEASE);
      columnas_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q    <= '0;
         estado_q   <= EST_SCAN;
         col_q      <= 2'd0;
         fila_q     <= 2'd0;
         deb_q      <= '0;
         tecla_q    <= TECLA_NUL;
         valida_q   <= 1'b0;
         activa_q   <= 1'b0;
         columnas_q <= 4'b1110;
      end else begin
         presc_q    <= tick ? '0 : presc_q + 1'b1;
         estado_q   <= estado_d;
         col_q      <= col_d;
         fila_q     <= fila_d;
         deb_q      <= deb_d;
         tecla_q    <= tecla_d;
         valida_q   <= valida_d;
         activa_q   <= activa_d;
         columnas_q <= columnas_d;
      end
   end

   assign columnas     = columnas_q;
   assign tecla        = tecla_q;
   assign tecla_valida = valida_q;
   assign tecla_activa = activa_q;

endmodule

// File: tb/tb_escaner_teclado.sv
// Bench for escaner_teclado: a keypad model drives the rows from the driven
// columns; a tick-level run-length model predicts every output each cycle.
module tb_escaner_teclado;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;

   logic       clk;
   logic       rst;
   logic [3:0] filas;
   logic [3:0] columnas;
   logic [3:0] tecla;
   logic       tecla_valida;
   logic       tecla_activa;
   logic [15:0] keys;   // bit r*4+c set = key at row r, column c held down

   escaner_teclado #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .filas        (filas),
      .columnas     (columnas),
      .tecla        (tecla),
      .tecla_valida (tecla_valida),
      .tecla_activa (tecla_activa)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] keypad(input logic [15:0] k, input logic [3:0] cols);
      logic [3:0] f;
      f = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (k[r*4+c] && (cols[c] == 1'b0)) f[r] = 1'b0;
      return f;
   endfunction

   assign filas = keypad(keys, columnas);

   logic [3:0] mapa [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hF, 4'h0, 4'hE, 4'hD};

   int n_checks, n_pass, n_fail;
   int dut_pulses, model_accepts;
   int ph, m_col, m_row, lo_run, hi_run;
   bit m_cap, m_acc, m_pulse, last_tick;
   logic [3:0] m_tecla;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      ph = 0; m_col = 0; m_row = 0; lo_run = 0; hi_run = 0;
      m_cap = 0; m_acc = 0; m_pulse = 0; m_tecla = 4'hF;
   endtask

   // One scan tick: idle / candidate (counting low ticks) / accepted (counting high ticks).
   task automatic model_tick();
      logic [3:0] bajas;
      bajas = ~keypad(keys, ~(4'b0001 << m_col));
      if (!m_cap) begin
         if (bajas != 4'h0) begin
            for (int r = 3; r >= 0; r--) if (bajas[r]) m_row = r;
            m_cap = 1; lo_run = 1;
         end else begin
            m_col = (m_col + 1) % 4;
         end
      end else if (!m_acc) begin
         if (bajas[m_row]) begin
            lo_run++;
            if (lo_run == DEB + 1) begin
               m_acc = 1; hi_run = 0; m_pulse = 1;
               m_tecla = mapa[m_row*4 + m_col];
               model_accepts++;
            end
         end else begin
            m_cap = 0; m_col = (m_col + 1) % 4;
         end
      end else begin
         if (bajas[m_row]) hi_run = 0;
         else              hi_run++;
         if (hi_run == DEB) begin
            m_acc = 0; m_cap = 0; m_col = (m_col + 1) % 4;
         end
      end
   endtask

   task automatic cycle();
      bit en_reset;
      bit tick;
      logic [3:0] col_esp;
      en_reset = rst;
      tick = 0;
      @(posedge clk);
      #1;
      if (en_reset) begin
         model_reset();
      end else begin
         m_pulse = 0;
         tick = (ph == SCAN_DIV - 1);
         ph = (ph + 1) % SCAN_DIV;
         if (tick) model_tick();
      end
      last_tick = tick;
      col_esp = ~(4'b0001 << m_col);
      chk("columnas", columnas, col_esp);
      chk("tecla", tecla, m_tecla);
      chk("tecla_valida", tecla_valida, m_pulse);
      chk("tecla_activa", tecla_activa, m_acc);
      if (tecla_valida === 1'b1) dut_pulses++;
   endtask

   task automatic run_ticks(input int n);
      int k;
      k = 0;
      while (k < n) begin
         cycle();
         if (last_tick) k++;
      end
   endtask

   task automatic wait_col(input int c);
      logic [3:0] col_esp;
      for (int i = 0; i < 16; i++) begin
         if (m_col == c && !m_cap) break;
         run_ticks(1);
      end
      col_esp = ~(4'b0001 << c);
      chk("wait_col", columnas, col_esp);
   endtask

   task automatic press_at(input int r, input int c, input int hold);
      wait_col(c);
      keys = 16'(1) << (r*4 + c);
      run_ticks(hold);
   endtask

   task automatic tap(input string tag, input int r, input int c, input logic [3:0] esperado);
      press_at(r, c, DEB + 2);
      chk(tag, tecla, esperado);
      keys = '0;
      run_ticks(DEB + 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      int r, c, prev;
      n_checks = 0; n_pass = 0; n_fail = 0;
      dut_pulses = 0; model_accepts = 0;
      keys = '0;
      rst = 1'b1;
      model_reset();

      // Reset and idle scan
      repeat (3) cycle();
      chk("reset_columnas", columnas, 4'b1110);
      chk("reset_tecla", tecla, 4'hF);
      chk("reset_valida", tecla_valida, 1'b0);
      chk("reset_activa", tecla_activa, 1'b0);
      rst = 1'b0;
      repeat (20) cycle();
      run_ticks(1);

      // Clean press of '6' and release
      press_at(1, 2, 6);
      chk("press6_tecla", tecla, 4'h6);
      chk("press6_activa", tecla_activa, 1'b1);
      chk("press6_columnas", columnas, 4'b1011);
      chk("press6_pulses", dut_pulses, 1);
      keys = '0;
      run_ticks(DEB);
      chk("release6_activa", tecla_activa, 1'b0);
      chk("release6_columnas", columnas, 4'b0111);

      // Bounce: low for 2 ticks only
      p0 = dut_pulses;
      press_at(2, 0, 2);
      keys = '0;
      run_ticks(3);
      chk("bounce_pulses", dut_pulses - p0, 0);
      chk("bounce_tecla", tecla, 4'h6);

      // Key map corners
      tap("map_0", 3, 1, 4'h0);
      tap("map_hash", 3, 2, 4'hE);
      tap("map_A", 0, 3, 4'hA);
      tap("map_star", 3, 0, 4'hF);

      // Two rows on column 0, long hold, chattering release
      wait_col(0);
      p0 = dut_pulses;
      keys = 16'h0101;
      repeat (1000) cycle();
      run_ticks(1);
      chk("multi_tecla", tecla, 4'h1);
      chk("multi_pulses", dut_pulses - p0, 1);
      keys = '0;     run_ticks(1);
      keys = 16'h0101; run_ticks(1);
      keys = '0;     run_ticks(2);
      chk("chatter_still_active", tecla_activa, 1'b1);
      run_ticks(1);
      chk("chatter_released", tecla_activa, 1'b0);
      chk("chatter_pulses", dut_pulses - p0, 1);

      // Reset while PRESSED
      press_at(0, 1, DEB + 1);
      chk("pre_reset_activa", tecla_activa, 1'b1);
      chk("pre_reset_tecla", tecla, 4'h2);
      p0 = dut_pulses;
      rst = 1'b1;
      cycle();
      chk("rst_pressed_columnas", columnas, 4'b1110);
      chk("rst_pressed_tecla", tecla, 4'hF);
      chk("rst_pressed_activa", tecla_activa, 1'b0);
      chk("rst_pressed_valida", tecla_valida, 1'b0);
      rst = 1'b0;
      keys = '0;
      repeat (8) cycle();
      chk("rst_pressed_pulses", dut_pulses - p0, 0);
      run_ticks(1);

      // Randomized presses, extra keys and release chatter
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(3);
         c = $urandom_range(3);
         keys = 16'(1) << (r*4 + c);
         if ($urandom_range(3) == 0) keys = keys | (16'(1) << $urandom_range(15));
         prev = int'(keys);
         run_ticks($urandom_range(1, 8));
         keys = '0;
         if ($urandom_range(1) == 1) begin
            run_ticks(1);
            keys = 16'(prev);
            run_ticks(1);
            keys = '0;
         end
         run_ticks($urandom_range(1, 6));
      end

      keys = '0;
      run_ticks(DEB + 2);
      chk("total_pulses", dut_pulses, model_accepts);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/escaner_teclado.md
# escaner_teclado

Scanner and debouncer for a 4×4 matrix keypad. It drives the keypad columns one at a time and samples the rows. After a debounced press it emits a 4-bit key code plus a one-cycle valid strobe. It sits directly upstream of the seven-segment converter: `tecla` feeds the converter's key-code input and `tecla_valida` feeds the calculator/display logic.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven; the row sample ("tick") happens on the last cycle of the dwell.
- `DEBOUNCE_CNT`, default 4: number of consecutive ticks a row must stay stable to accept a press or a release (≥1).
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `filas` in 4: keypad rows, active-low (pulled up), asynchronous.
- `columnas` out 4: keypad columns, one-cold active-low drive.
- `tecla` out 4: last accepted key code, held until the next accepted press.
- `tecla_valida` out 1: one-cycle pulse when `tecla` updates.
- `tecla_activa` out 1: high while an accepted key is held (PRESSED and RELEASE states).

## Operation
- **Row synchronizer.** `filas` passes through a 2-flop synchronizer (`filas_s`). All decisions use `filas_s`, sampled only on a tick.
- **Prescaler.** Counts 0..SCAN_DIV-1 continuously; tick = count at SCAN_DIV-1.
- **Column drive.** `col_idx` is 2 bits; `columnas = ~(4'b0001 << col_idx)`.
- **Key map (row, col → code).**
  - r0: 1,2,3,A → 1,2,3,A
  - r1: 4,5,6,B → 4,5,6,B
  - r2: 7,8,9,C → 7,8,9,C
  - r3: *,0,#,D → F,0,E,D
  - Meaning: A=+, B=−, C=×, D=÷, E='=', F=null/clear.
- **FSM states:** SCAN, DEBOUNCE, PRESSED, RELEASE.
- **SCAN.**
  - Tick with `filas_s`==4'hF: advance `col_idx` (wraps 3→0).
  - Tick with any row low: latch the lowest-index low row into `fila_cap`, clear `deb_cnt`, go DEBOUNCE. The column stays frozen.
- **DEBOUNCE.**
  - Tick with `fila_cap` still low: `deb_cnt`++.
  - When `deb_cnt` reaches DEBOUNCE_CNT: go PRESSED, load `tecla`, pulse `tecla_valida`.
  - Tick with `fila_cap` high: go SCAN, advance column, no output.
- **PRESSED.**
  - Column frozen, `tecla_activa`=1.
  - Tick with `fila_cap` high: go RELEASE, `deb_cnt`=1.
- **RELEASE.**
  - Tick with `fila_cap` high: `deb_cnt`++.
  - Tick with `fila_cap` low: `deb_cnt`=0 and stay in RELEASE. No new pulse.
  - When `deb_cnt` reaches DEBOUNCE_CNT: go SCAN, advance column, `tecla_activa`=0.
- **Multiple keys.** Lowest row wins within the scanned column. Other keys are ignored until the accepted key is released.
- **Reset values.** State=SCAN, `col_idx`=0, `columnas`=4'b1110, `tecla`=4'hF, `tecla_valida`=0, `tecla_activa`=0, prescaler=0, `deb_cnt`=0, synchronizer=4'hF.
- **Reset mid-operation** (any state) aborts the operation; all registers take reset values next cycle. No pulse is emitted.

## Timing
- All outputs are registered.
- `tecla` and `tecla_valida` change in the same cycle, exactly one clock after the accepting tick.
- `tecla_valida` is high for exactly 1 cycle per accepted press.
- **Press latency** from the first stable-low tick: DEBOUNCE_CNT further ticks + 1 cycle.
- **Row input latency:** 2 cycles through the synchronizer before a tick sees it.
- **Column change:** `columnas` changes one cycle after the advancing tick. The first sample of the new column occurs SCAN_DIV cycles later, which allows settling.
- **Simultaneous events:** a tick coinciding with reset is ignored.

## Structure
- **Shared package/include.**
  - Key-code constants: `TECLA_0..TECLA_9`, `TECLA_MAS`=A, `TECLA_MENOS`=B, `TECLA_POR`=C, `TECLA_DIV`=D, `TECLA_IGUAL`=E, `TECLA_NUL`=F. The converter uses the same constants.
  - FSM state encoding.
  - (row, col)→code mapping function.
- **Sub-module:** `sincronizador_filas`, a 4-bit 2-flop synchronizer with reset value 4'hF.
- **Top-level contents:** prescaler, FSM and counters.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3.
- **Reset and idle scan.** Hold rst then release with no keys pressed → `tecla`=F, flags 0; `columnas` cycles 1110→1101→1011→0111→1110, 4 cycles per step.
- **Single clean press.** Hold row1 low while col2 is driven ('6'), held clean → one `tecla_valida` pulse, `tecla`=4'h6, `tecla_activa`=1, `columnas` frozen at 1011. Release → `tecla_activa` drops after 3 high ticks; scanning resumes at 0111.
- **Bounce rejection.** Row low for 2 ticks, then high → no pulse, `tecla` unchanged, column advances.
- **Map check.** '0' (r3,c1) → 4'h0; '#' (r3,c2) → 4'hE; 'A' (r0,c3) → 4'hA; '*' (r3,c0) → 4'hF.
- **Multi-key and long hold.** Rows 0 and 2 low on col0 → `tecla`=1. Hold 1000 cycles → exactly one pulse. Release chatter (high, low, high×3) → no second pulse.
- **Reset in PRESSED.** Assert rst while PRESSED → next cycle `columnas`=1110, `tecla`=F, `tecla_activa`=0, no pulse.
